spm_memory_unit: RTL and testbench
==================================

# spm_memory_unit

Memory responder for the RISC_SPM processor: a 2^ADDR_W x DATA_W RAM with its own address register, serving the control unit's address-load / read / write requests. A boot-load port fills the RAM from an external byte stream while the processor is held in reset, then releases it. Sits between the processor datapath buses and the testbench/host loader.

## Interface
- ADDR_W, 8, address width; RAM depth is 2^ADDR_W
- DATA_W, 8, word width; must equal ADDR_W (addresses travel on Bus_2)
- PROT_TOP, 8'h0F, highest protected address (used only with WR_PROTECT_EN)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- bus_2  input  DATA_W  processor Bus_2; address source for load_add_r
- bus_1  input  DATA_W  processor Bus_1; write data
- load_add_r  input  1  load address register from bus_2
- write  input  1  write bus_1 to RAM[addr_reg]
- mem_word  output  DATA_W  RAM[addr_reg], combinational from the address register
- boot_start  input  1  begin a boot load (sampled in B_IDLE only)
- boot_valid  input  1  boot byte present on boot_data
- boot_data  input  DATA_W  boot byte
- boot_ready  output  1  unit accepts boot_data this cycle
- cpu_rst_n  output  1  processor reset (active-low); 0 until boot complete
- wr_err  output  1  sticky write-violation flag (0 when WR_PROTECT_EN absent)

## Operation
- FSM states: B_IDLE, B_LEN, B_LOAD, RUN. Reset -> B_IDLE.
- Reset values: addr_reg=0, byte counter=0, boot_ready=0, cpu_rst_n=0, wr_err=0. RAM contents not reset.
- B_IDLE: boot_ready=0, cpu_rst_n=0. boot_start=1 -> B_LEN.
- B_LEN: boot_ready=1. Transfer when boot_valid&&boot_ready: byte = length N, counter <= N, load address <= 0 -> B_LOAD. N=0 means 2^ADDR_W bytes.
- B_LOAD: boot_ready=1. Each transfer writes RAM[load address] <= boot_data, increments load address (wraps), decrements counter (mod 2^ADDR_W). Transfer of the last byte (counter==1, or counter==0 after a full 256-byte count wrapping to 1) -> RUN. Cycles with boot_valid=0 change nothing.
- RUN: boot_ready=0, cpu_rst_n=1, boot_start ignored. Only leaves RUN on rst.
- Processor port active only in RUN; load_add_r/write ignored in other states.
- load_add_r=1: addr_reg <= bus_2 at the edge.
- write=1: RAM[addr_reg] <= bus_1 at the edge, using addr_reg value before any same-cycle load.
- write and load_add_r same cycle: write uses old addr_reg, addr_reg then updates.
- mem_word = RAM[addr_reg] at all times (asynchronous read); write to current address visible on mem_word the cycle after the edge.
- rst mid-boot: returns to B_IDLE, cpu_rst_n=0, partially loaded bytes remain in RAM; a new boot_start restarts from address 0.

## Timing
- Boot handshake: one byte per cycle max; transfer = boot_valid&&boot_ready at rising edge.
- cpu_rst_n rises the cycle after the final byte's transfer edge (registered).
- Address load latency: 1 edge; mem_word valid combinationally after that edge, satisfying the control unit's fet1->fet2 and rd1->rd2 sequences with zero wait states.
- Write latency: 1 edge.

## Configuration
- WR_PROTECT_EN defined: processor writes with addr_reg <= PROT_TOP are suppressed (RAM unchanged) and set wr_err=1, sticky until rst. Boot writes are never protected.
- WR_PROTECT_EN undefined: all RUN writes performed; wr_err tied to 0.

## Test plan
- Boot N=3 bytes 8'h51,8'h00,8'h7A with continuous valid -> RAM[0..2] hold them, cpu_rst_n=1 exactly one cycle after 4th transfer, boot_ready=0 thereafter.
- Boot with boot_valid gaps (valid every other cycle), N=2 -> same final contents, no extra/lost bytes; N=0 -> 256 bytes accepted, last byte lands at 8'hFF.
- RUN: load_add_r with bus_2=8'h20, next cycle write with bus_1=8'hC3 -> following cycle mem_word=8'hC3; load_add_r bus_2=8'h00 -> mem_word=RAM[0].
- Simultaneous write+load_add_r (addr_reg=8'h20, bus_2=8'h30, bus_1=8'h11) -> RAM[8'h20]=8'h11, addr_reg=8'h30.
- rst asserted after 1 of 3 boot bytes -> B_IDLE, cpu_rst_n=0, boot_ready=0; processor writes before new boot have no effect.
- WR_PROTECT_EN: write 8'hAA at addr 8'h05 -> RAM unchanged, wr_err=1 and stays 1; write at 8'h10 succeeds.

Source files
------------

// File: rtl/spm_memory_unit.sv
// Memory responder for RISC_SPM: RAM with its own address register plus a boot loader that
// fills the RAM from a byte stream before releasing cpu_rst_n. Optional macro: WR_PROTECT_EN.
module spm_memory_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
`ifdef WR_PROTECT_EN
  ,
  parameter logic [ADDR_W-1:0] PROT_TOP = 8'h0F
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_2,
  input  logic [DATA_W-1:0] bus_1,
  input  logic              load_add_r,
  input  logic              write,
  output logic [DATA_W-1:0] mem_word,
  input  logic              boot_start,
  input  logic              boot_valid,
  input  logic [DATA_W-1:0] boot_data,
  output logic              boot_ready,
  output logic              cpu_rst_n,
  output logic              wr_err
);

  localparam int unsigned Depth = 1 << ADDR_W;

  typedef enum logic [1:0] {StBIdle, StBLen, StBLoad, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   load_addr_q, load_addr_d;
  logic [DATA_W-1:0]   mem_q [Depth];

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;

`ifdef WR_PROTECT_EN
  logic wr_err_q, wr_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    load_addr_d = load_addr_q;
    boot_ready  = 1'b0;
    cpu_rst_n   = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = addr_q;
    ram_wdata   = bus_1;
`ifdef WR_PROTECT_EN
    wr_err_d    = wr_err_q;
`endif
    unique case (state_q)
      StBIdle: begin
        if (boot_start) state_d = StBLen;
      end
      StBLen: begin
        boot_ready = 1'b1;
        if (boot_valid) begin
          // Length 0 decrements to all-ones and so counts the full 2^ADDR_W bytes.
          cnt_d       = boot_data[ADDR_W-1:0];
          load_addr_d = '0;
          state_d     = StBLoad;
        end
      end
      StBLoad: begin
        boot_ready = 1'b1;
        if (boot_valid) begin
          ram_we      = 1'b1;
          ram_waddr   = load_addr_q;
          ram_wdata   = boot_data;
          load_addr_d = load_addr_q + ADDR_W'(1);
          cnt_d       = cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) state_d = StRun;
        end
      end
      StRun: begin
        cpu_rst_n = 1'b1;
        if (load_add_r) addr_d = bus_2[ADDR_W-1:0];
        // Write targets the address held before any same-cycle load.
        if (write) begin
`ifdef WR_PROTECT_EN
          if (addr_q <= PROT_TOP) wr_err_d = 1'b1;
          else                    ram_we   = 1'b1;
`else
          ram_we = 1'b1;
`endif
        end
      end
      default: state_d = StBIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBIdle;
      addr_q      <= '0;
      cnt_q       <= '0;
      load_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      load_addr_q <= load_addr_d;
    end
  end

`ifdef WR_PROTECT_EN
  always_ff @(posedge clk) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_err_d;
  end
  assign wr_err = wr_err_q;
`else
  assign wr_err = 1'b0;
`endif

  // RAM contents survive reset by design.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
  end

  assign mem_word = mem_q[addr_q];

endmodule

// File: tb/tb_spm_memory_unit.sv
// Scoreboard bench for spm_memory_unit: stimulus queues expectations, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_spm_memory_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bus_2, bus_1, boot_data, mem_word;
  logic       load_add_r, write, boot_start, boot_valid;
  logic       boot_ready, cpu_rst_n, wr_err;

  spm_memory_unit dut (
    .clk        (clk),
    .rst        (rst),
    .bus_2      (bus_2),
    .bus_1      (bus_1),
    .load_add_r (load_add_r),
    .write      (write),
    .mem_word   (mem_word),
    .boot_start (boot_start),
    .boot_valid (boot_valid),
    .boot_data  (boot_data),
    .boot_ready (boot_ready),
    .cpu_rst_n  (cpu_rst_n),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  localparam int KMem   = 0;
  localparam int KCpu   = 1;
  localparam int KReady = 2;
  localparam int KErr   = 3;

  typedef struct {
    int         kind;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] boot_buf [256];

`ifdef WR_PROTECT_EN
  localparam bit Prot = 1'b1;
`else
  localparam bit Prot = 1'b0;
`endif

  // Monitor: compares every queued expectation on the falling edge.
  exp_t       m_e;
  logic [7:0] m_act;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      case (m_e.kind)
        KMem:    m_act = mem_word;
        KCpu:    m_act = {7'd0, cpu_rst_n};
        KReady:  m_act = {7'd0, boot_ready};
        default: m_act = {7'd0, wr_err};
      endcase
      n_checks++;
      if (m_act !== m_e.val) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", m_e.name, m_act, m_e.val);
      end
    end
  end

  function automatic void push(input int kind, input logic [7:0] v, input string nm);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [7:0] a);
    load_add_r = 1'b1;
    bus_2      = a;
    tick();
    load_add_r = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    write = 1'b1;
    bus_1 = d;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp_v, input string nm);
    ld(a);
    push(KMem, exp_v, nm);
  endtask

  // Sends length byte then n_bytes from boot_buf; gaps inserts an idle cycle before each byte.
  task automatic boot(input logic [7:0] len, input int n_bytes, input bit gaps);
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    for (int i = 0; i <= n_bytes; i++) begin
      if (gaps) begin
        boot_valid = 1'b0;
        tick();
      end
      push(KReady, 8'd1, "boot_ready_before_xfer");
      push(KCpu, 8'd0, "cpu_rst_n_held_during_boot");
      boot_valid = 1'b1;
      boot_data  = (i == 0) ? len : boot_buf[i-1];
      tick();
      boot_valid = 1'b0;
    end
    push(KCpu, 8'd1, "cpu_rst_n_after_last_byte");
    push(KReady, 8'd0, "boot_ready_after_boot");
  endtask

  initial begin
    rst = 1'b1; bus_2 = '0; bus_1 = '0; load_add_r = 1'b0; write = 1'b0;
    boot_start = 1'b0; boot_valid = 1'b0; boot_data = '0;
    tick();
    tick();
    push(KCpu, 8'd0, "reset_cpu_rst_n");
    push(KReady, 8'd0, "reset_boot_ready");
    push(KErr, 8'd0, "reset_wr_err");
    rst = 1'b0;
    tick();
    push(KReady, 8'd0, "idle_boot_ready");

    // Three-byte continuous boot.
    boot_buf[0] = 8'h51; boot_buf[1] = 8'h00; boot_buf[2] = 8'h7A;
    boot(8'd3, 3, 1'b0);
    rd(8'h00, 8'h51, "boot3_ram0");
    rd(8'h01, 8'h00, "boot3_ram1");
    rd(8'h02, 8'h7A, "boot3_ram2");

    ld(8'h20);
    wr(8'hC3);
    push(KMem, 8'hC3, "write_then_read");
    rd(8'h00, 8'h51, "load_addr_zero");

    // Write and load together: write hits 0x20, address moves to 0x30.
    ld(8'h20);
    load_add_r = 1'b1; bus_2 = 8'h30; write = 1'b1; bus_1 = 8'h11;
    tick();
    load_add_r = 1'b0; write = 1'b0;
    wr(8'h77);
    rd(8'h20, 8'h11, "simul_write_old_addr");
    rd(8'h30, 8'h77, "simul_load_new_addr");

    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    push(KCpu, 8'd1, "run_ignores_boot_start_cpu");
    push(KReady, 8'd0, "run_ignores_boot_start_ready");

    ld(8'h40);
    wr(8'h5A);
    push(KMem, 8'h5A, "write_0x40");

    ld(8'h02);
    wr(8'hAA);
    push(KMem, Prot ? 8'h7A : 8'hAA, "write_low_addr");
    push(KErr, Prot ? 8'd1 : 8'd0, "wr_err_low_addr");
    ld(8'h10);
    wr(8'h3E);
    push(KMem, 8'h3E, "write_0x10");
    push(KErr, Prot ? 8'd1 : 8'd0, "wr_err_sticky");

    // Reset in the middle of a boot.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(KCpu, 8'd0, "rst_cpu_rst_n");
    push(KReady, 8'd0, "rst_boot_ready");
    push(KErr, 8'd0, "rst_clears_wr_err");
    boot_start = 1'b1;
    tick();
    boot_start = 1'b0;
    boot_valid = 1'b1; boot_data = 8'd3;
    tick();
    boot_data = 8'hE1;
    tick();
    boot_valid = 1'b0;
    push(KReady, 8'd1, "mid_boot_ready");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push(KCpu, 8'd0, "mid_rst_cpu_rst_n");
    push(KReady, 8'd0, "mid_rst_boot_ready");
    load_add_r = 1'b1; bus_2 = 8'h40; write = 1'b1; bus_1 = 8'h99;
    tick();
    load_add_r = 1'b0; write = 1'b0;
    push(KCpu, 8'd0, "idle_proc_port_cpu");

    // Gapped two-byte boot.
    boot_buf[0] = 8'h3C; boot_buf[1] = 8'hD4;
    boot(8'd2, 2, 1'b1);
    push(KMem, 8'h3C, "idle_load_ignored");
    rd(8'h01, 8'hD4, "gap_ram1");
    rd(8'h02, Prot ? 8'h7A : 8'hAA, "gap_no_extra_byte");
    rd(8'h40, 8'h5A, "idle_write_ignored");

    // Full 256-byte boot via length 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) boot_buf[i] = 8'(i) ^ 8'h5A;
    boot(8'd0, 256, 1'b0);
    rd(8'hFF, 8'hA5, "full_last_byte");
    rd(8'h00, 8'h5A, "full_first_byte");
    rd(8'h80, 8'hDA, "full_mid_byte");

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
